async_mem_master: RTL
=====================

Name: async_mem_master

Overview:
- Wishbone slave that converts 32-bit bus cycles into timed 16-bit asynchronous memory cycles (PSRAM/parallel flash on the shared board data bus).
- Sits directly upstream of the shared-bus data-direction switch. Drives that switch's per-master chip-enable, drive-enable and outbound data. Consumes its inbound data.
- Also drives the memory control strobes and address.

Parameters:
- adr_width, 23: halfword address width to memory.
- rd_wait, 6: ACCESS cycles per read half. Legal range 1..15.
- wr_wait, 6: ACCESS cycles per write half. Legal range 1..15.

Ports:
- sys_clk  in  1  system clock; all state on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- wb_adr_i  in  32  byte address. Bits [adr_width:2] select the 32-bit word.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, registered.
- wb_sel_i  in  4  byte selects.
- wb_we_i  in  1  write request.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle valid.
- wb_ack_o  out  1  one-cycle acknowledge.
- mem_adr  out  adr_width  halfword address.
- mem_ce  out  1  to switch: this master owns the bus.
- mem_oe  out  1  to switch: FPGA drives the data pins.
- mem_do  out  16  to switch: outbound data.
- mem_di  in  16  from switch: inbound data.
- mem_ce_n  out  1  memory chip enable, active low.
- mem_oe_n  out  1  memory output enable, active low.
- mem_we_n  out  1  memory write enable, active low.
- mem_ub_n  out  1  upper byte enable, active low.
- mem_lb_n  out  1  lower byte enable, active low.

Behaviour:
- Reset values (async assert, sync release):
  - wb_ack_o=0, wb_dat_o=0, mem_adr=0, mem_do=0.
  - mem_ce=0, mem_oe=0.
  - mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n all 1.
  - State IDLE.
- Reset mid-operation: all strobes go inactive immediately; no ack is issued.
- All outputs are registered; no combinational path from wb_* to mem_*.
- Halves and byte order (big-endian):
  - Half 0 = word bits [31:16], mem_adr = {wb_adr_i[adr_width:2],1'b0}, byte enables from sel[3:2].
  - Half 1 = word bits [15:0], mem_adr = {...,1'b1}, byte enables from sel[1:0].
- Half selection:
  - Reads always perform both halves, with ub_n/lb_n both 0.
  - Writes skip any half whose two sel bits are 0.
  - A write with sel=0 performs no memory cycle and acks directly.
  - ub_n/lb_n = inverse of the half's sel bits.
- States: IDLE, SETUP, ACCESS, HOLD, ACK.
- IDLE:
  - If wb_cyc_i & wb_stb_i & !wb_ack_o: latch address, data, sel and we; choose first half.
  - Go to SETUP, or to ACK if no half is needed.
- SETUP (1 cycle):
  - mem_ce=1, mem_ce_n=0, address and byte enables valid.
  - mem_oe=1 and mem_do=half data for writes; mem_oe=0 for reads.
  - mem_oe_n=1, mem_we_n=1.
  - Load the 4-bit wait counter with rd_wait-1 or wr_wait-1.
- ACCESS (rd_wait or wr_wait cycles):
  - Read: mem_oe_n=0.
  - Write: mem_we_n=0, data held.
  - Counter decrements each cycle; leave when counter==0.
  - Read data: mem_di is captured into the half's wb_dat_o slice in the last ACCESS cycle. The slice not being read is unchanged.
- HOLD (1 cycle):
  - mem_oe_n=1, mem_we_n=1.
  - ce and address held; write data still driven, mem_oe stays 1.
  - Next: SETUP of the remaining needed half, else ACK.
- ACK (1 cycle):
  - wb_ack_o=1; mem_ce=0, mem_oe=0, mem_ce_n=1.
  - Return to IDLE. A request is never accepted in the ACK cycle; this is the bus turnaround cycle.
- Latency: with stb sampled at cycle 0, ack occurs at cycle N·(W+2)+1, where N is the number of halves (0..2) and W the wait count.
- mem_ce stays continuously 1 from the first SETUP through the last HOLD, so the switch never hands the bus to the other master mid-word.
- Cycle abort: if wb_cyc_i drops before ACK:
  - The current half completes through HOLD, so memory timing is never truncated.
  - The FSM then returns to IDLE with no ack; mem_ce=0 and all strobes inactive.
- Writes never alter wb_dat_o.

Test Plan:
- Read, rd_wait=6, address 0x100; memory returns 0x1234 at halfword 0x80 and 0xABCD at 0x81 -> wb_dat_o=0x1234ABCD. Ack at cycle 17. mem_oe=0 throughout. mem_oe_n low for exactly 6 cycles per half.
- Write 0xDEADBEEF, sel=4'hF -> halfword 0x80 gets 0xDEAD, 0x81 gets 0xBEEF. mem_we_n low 6 cycles each. mem_oe=1 in SETUP through HOLD. Ack at cycle 17.
- Write sel=4'b0001 -> only half 1 is written, ub_n=1, lb_n=0. Ack at cycle 9. sel=0 -> no mem_ce pulse, ack at cycle 1.
- wb_cyc_i dropped during half-0 ACCESS of a read -> half 0 completes, no half-1 SETUP, no ack. mem_ce=0 by the following cycle.
- sys_rst_n asserted during write ACCESS -> mem_we_n=1, mem_ce=0, mem_oe=0 without a clock edge. After release, a new read succeeds normally.
- Back-to-back reads with stb held high -> exactly one ack per cycle. The second request starts SETUP no earlier than 2 cycles after the first ack, and mem_ce is low for at least 1 cycle between them.

Source files
------------

// File: rtl/async_mem_master.sv
// Wishbone slave that splits 32-bit bus cycles into timed 16-bit asynchronous
// memory cycles and drives the shared-bus switch's ownership/direction inputs.
module async_mem_master #(
    parameter int adr_width = 23,
    parameter int rd_wait   = 6,
    parameter int wr_wait   = 6
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [31:0]          wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_we_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_cyc_i,
    output logic                 wb_ack_o,
    output logic [adr_width-1:0] mem_adr,
    output logic                 mem_ce,
    output logic                 mem_oe,
    output logic [15:0]          mem_do,
    input  logic [15:0]          mem_di,
    output logic                 mem_ce_n,
    output logic                 mem_oe_n,
    output logic                 mem_we_n,
    output logic                 mem_ub_n,
    output logic                 mem_lb_n
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_HOLD   = 3'd3,
        S_ACK    = 3'd4
    } state_t;

    localparam logic [3:0] RD_CNT = 4'(rd_wait - 1);
    localparam logic [3:0] WR_CNT = 4'(wr_wait - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_we;
    logic                  w_we_nxt;
    logic [adr_width-2:0]  r_word;
    logic [adr_width-2:0]  w_word_nxt;
    logic [31:0]           r_dat;
    logic [31:0]           w_dat_nxt;
    logic [3:0]            r_sel;
    logic [3:0]            w_sel_nxt;
    logic                  r_half;
    logic                  w_half_nxt;
    logic                  r_need1;
    logic                  w_need1_nxt;
    logic                  r_abort;
    logic                  w_abort_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;

    logic                  w_need_hi;
    logic                  w_need_lo;
    logic                  w_busy_nxt;
    logic                  w_ack_nxt;
    logic                  w_ce_nxt;
    logic                  w_oe_nxt;
    logic [15:0]           w_do_nxt;
    logic [adr_width-1:0]  w_adr_nxt;
    logic                  w_ce_n_nxt;
    logic                  w_oe_n_nxt;
    logic                  w_we_n_nxt;
    logic                  w_ub_n_nxt;
    logic                  w_lb_n_nxt;
    logic                  w_unused;

    assign w_unused  = ^{wb_adr_i[31:adr_width+1], wb_adr_i[1:0]};
    assign w_need_hi = !wb_we_i || (|wb_sel_i[3:2]);
    assign w_need_lo = !wb_we_i || (|wb_sel_i[1:0]);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= S_IDLE;
            r_half   <= 1'b0;
            r_need1  <= 1'b0;
            r_abort  <= 1'b0;
            r_cnt    <= 4'd0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'd0;
            mem_adr  <= '0;
            mem_do   <= 16'd0;
            mem_ce   <= 1'b0;
            mem_oe   <= 1'b0;
            mem_ce_n <= 1'b1;
            mem_oe_n <= 1'b1;
            mem_we_n <= 1'b1;
            mem_ub_n <= 1'b1;
            mem_lb_n <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_half   <= w_half_nxt;
            r_need1  <= w_need1_nxt;
            r_abort  <= w_abort_nxt;
            r_cnt    <= w_cnt_nxt;
            wb_ack_o <= w_ack_nxt;
            mem_adr  <= w_adr_nxt;
            mem_do   <= w_do_nxt;
            mem_ce   <= w_ce_nxt;
            mem_oe   <= w_oe_nxt;
            mem_ce_n <= w_ce_n_nxt;
            mem_oe_n <= w_oe_n_nxt;
            mem_we_n <= w_we_n_nxt;
            mem_ub_n <= w_ub_n_nxt;
            mem_lb_n <= w_lb_n_nxt;
            // Sample the memory while oe_n is still low in the last access cycle.
            if (r_state == S_ACCESS && r_cnt == 4'd0 && !r_we) begin
                if (r_half) begin
                    wb_dat_o[15:0] <= mem_di;
                end else begin
                    wb_dat_o[31:16] <= mem_di;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        r_we   <= w_we_nxt;
        r_word <= w_word_nxt;
        r_dat  <= w_dat_nxt;
        r_sel  <= w_sel_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we_nxt    = r_we;
        w_word_nxt  = r_word;
        w_dat_nxt   = r_dat;
        w_sel_nxt   = r_sel;
        w_half_nxt  = r_half;
        w_need1_nxt = r_need1;
        w_abort_nxt = r_abort;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i && !wb_ack_o) begin
                    w_we_nxt    = wb_we_i;
                    w_word_nxt  = wb_adr_i[adr_width:2];
                    w_dat_nxt   = wb_dat_i;
                    w_sel_nxt   = wb_sel_i;
                    w_abort_nxt = 1'b0;
                    w_half_nxt  = !w_need_hi;
                    w_need1_nxt = w_need_hi && w_need_lo;
                    w_state_nxt = (w_need_hi || w_need_lo) ? S_SETUP : S_ACK;
                end
            end
            S_SETUP: begin
                w_cnt_nxt   = r_we ? WR_CNT : RD_CNT;
                w_abort_nxt = r_abort || !wb_cyc_i;
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                w_abort_nxt = r_abort || !wb_cyc_i;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_HOLD: begin
                // An abandoned cycle still finishes the current half before releasing the bus.
                if (r_abort || !wb_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_need1) begin
                    w_half_nxt  = 1'b1;
                    w_need1_nxt = 1'b0;
                    w_state_nxt = S_SETUP;
                end else begin
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_busy_nxt = (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS) ||
                        (w_state_nxt == S_HOLD);

    always_comb begin
        w_ack_nxt  = (w_state_nxt == S_ACK);
        w_ce_nxt   = 1'b0;
        w_oe_nxt   = 1'b0;
        w_do_nxt   = mem_do;
        w_adr_nxt  = mem_adr;
        w_ce_n_nxt = 1'b1;
        w_oe_n_nxt = 1'b1;
        w_we_n_nxt = 1'b1;
        w_ub_n_nxt = 1'b1;
        w_lb_n_nxt = 1'b1;
        if (w_busy_nxt) begin
            w_ce_nxt   = 1'b1;
            w_ce_n_nxt = 1'b0;
            w_oe_nxt   = w_we_nxt;
            w_adr_nxt  = {w_word_nxt, w_half_nxt};
            if (w_we_nxt) begin
                w_do_nxt   = w_half_nxt ? w_dat_nxt[15:0] : w_dat_nxt[31:16];
                w_ub_n_nxt = w_half_nxt ? !w_sel_nxt[1] : !w_sel_nxt[3];
                w_lb_n_nxt = w_half_nxt ? !w_sel_nxt[0] : !w_sel_nxt[2];
            end else begin
                w_ub_n_nxt = 1'b0;
                w_lb_n_nxt = 1'b0;
            end
            if (w_state_nxt == S_ACCESS) begin
                w_oe_n_nxt = w_we_nxt;
                w_we_n_nxt = !w_we_nxt;
            end
        end
    end

endmodule
